mult_seq_16bit: RTL and testbench

MULT_SEQ_16BIT -- requirements
Module: mult_seq_16bit

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_4bit.sv | 12 +
 rtl/mult_seq_16bit.sv | 106 ++++++++++
 tb/tb_mult_seq_16bit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, FSM encoding and nibble select for the sequential multiplier
package mult_pkg;

   localparam int NIB_W  = 4;
   localparam int OP_W   = 16;
   localparam int PROD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [NIB_W-1:0] nib_sel(input logic [OP_W-1:0] op,
                                                input logic [1:0]      idx);
      return op[idx*NIB_W +: NIB_W];
   endfunction

endpackage

// File: rtl/mult_4bit.sv
// rtl/mult_4bit.sv - 4x4 unsigned multiplier, the only multiply in the datapath
module mult_4bit
   import mult_pkg::*;
(
   input  logic [NIB_W-1:0]   a,
   input  logic [NIB_W-1:0]   b,
   output logic [2*NIB_W-1:0] c
);

   assign c = {{NIB_W{1'b0}}, a} * {{NIB_W{1'b0}}, b};

endmodule

// File: rtl/mult_seq_16bit.sv
// rtl/mult_seq_16bit.sv - 16x16 unsigned multiplier, one nibble pair per cycle over a shared 4x4 core
module mult_seq_16bit
   import mult_pkg::*;
#(
   parameter bit ZERO_SKIP = 1'b1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] p,
   output logic              busy
);

   state_e              state_q, state_d;
   logic [NIB_W-1:0]    cnt_q, cnt_d;
   logic [OP_W-1:0]     a_q, a_d;
   logic [OP_W-1:0]     b_q, b_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic                rdy_q;

   logic [NIB_W-1:0]    nib_a;
   logic [NIB_W-1:0]    nib_b;
   logic [2*NIB_W-1:0]  pp;
   logic [4:0]          shamt;
   logic                accept;

   assign accept = rdy_q & in_valid;

   // cnt[1:0] walks the multiplicand nibbles, cnt[3:2] the multiplier nibbles
   assign nib_a = nib_sel(a_q, cnt_q[1:0]);
   assign nib_b = nib_sel(b_q, cnt_q[3:2]);
   assign shamt = {({1'b0, cnt_q[1:0]} + {1'b0, cnt_q[3:2]}), 2'b00};

   mult_4bit u_mult (
      .a (nib_a),
      .b (nib_b),
      .c (pp)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               a_d   = a;
               b_d   = b;
               acc_d = '0;
               cnt_d = '0;
               if (ZERO_SKIP && ((a == '0) || (b == '0))) begin
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = acc_q + (PROD_W'(pp) << shamt);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // in_ready is a register so it stays low through reset and rises one cycle after release
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         rdy_q   <= (state_d == IDLE);
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == CALC);
   assign p         = acc_q;

endmodule

// File: tb/tb_mult_seq_16bit.sv
// tb/tb_mult_seq_16bit.sv - directed and random checks of mult_seq_16bit
module tb_mult_seq_16bit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] p;
   logic        busy;

   int n_vec;
   int n_err;
   int lat;
   int nb;

   mult_seq_16bit #(.ZERO_SKIP(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   task automatic start(input logic [15:0] av, input logic [15:0] bv);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("start_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat_o, output int nbusy_o);
      lat_o   = 1;
      nbusy_o = 0;
      while (!out_valid && lat_o < 40) begin
         if (busy) nbusy_o++;
         @(negedge clk);
         lat_o++;
      end
      if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic [31:0] exp_p, input int exp_lat, input int exp_busy);
      start(av, bv);
      wait_valid(lat, nb);
      chk({tag, "_p"}, p, exp_p);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy"}, 32'(nb), 32'(exp_busy));
      handshake();
      chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [31:0] ref_p;
      logic        seen;
      logic        done_hs;

      n_vec     = 0;
      n_err     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_p", p, 32'd0);
      rst = 1'b0;
      chk("rst_release_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      directed("m1234", 16'h1234, 16'h5678, 32'h0626_0060, 17, 16);
      directed("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 16);
      directed("zero_a", 16'h0000, 16'hBEEF, 32'h0000_0000, 1, 0);
      directed("zero_b", 16'h1234, 16'h0000, 32'h0000_0000, 1, 0);
      directed("one", 16'h0001, 16'h0001, 32'h0000_0001, 17, 16);
      directed("shift", 16'h8000, 16'h0002, 32'h0001_0000, 17, 16);

      // stall in DONE with a competing request held on the input
      start(16'h0011, 16'h0022);
      in_valid = 1'b1;
      a        = 16'h0003;
      b        = 16'h0005;
      wait_valid(lat, nb);
      chk("stall_lat", 32'(lat), 32'd17);
      for (int i = 0; i < 5; i++) begin
         chk("stall_p", p, 32'h0000_0242);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      chk("stall_p_end", p, 32'h0000_0242);
      handshake();
      chk("hs_in_ready", 32'(in_ready), 32'd1);
      chk("hs_no_accept", 32'(out_valid | busy), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(lat, nb);
      chk("held_p", p, 32'h0000_000F);
      chk("held_lat", 32'(lat), 32'd17);
      handshake();

      // abort in the middle of a calculation
      start(16'h00FF, 16'h0101);
      repeat (7) @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy_rst", 32'(busy), 32'd0);
      chk("abort_p", p, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (20) begin
         if (out_valid || busy) seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_result", 32'(seen), 32'd0);
      directed("after_abort", 16'h0002, 16'h0003, 32'h0000_0006, 17, 16);

      // back-to-back random operands against a reference product
      for (int k = 0; k < 1000; k++) begin
         ra    = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
         rb    = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
         ref_p = 32'(ra) * 32'(rb);
         start(ra, rb);
         wait_valid(lat, nb);
         chk("rand_p", p, ref_p);
         done_hs = 1'b0;
         for (int w = 0; w < 20 && !done_hs; w++) begin
            out_ready = 1'($urandom_range(0, 1));
            done_hs   = out_ready;
            @(negedge clk);
         end
         if (!done_hs) begin
            out_ready = 1'b1;
            @(negedge clk);
         end
         out_ready = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
